// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the E stage.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the E stage, owns the
// HI/LO registers and models fixed multi-cycle latency for mult/div. The full
// result is computed in the start cycle and parked in res_hi/res_lo. It is
// committed to HI/LO when the latency counter expires.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   en       in   E-stage instruction valid
//   op       in   [3:0] operation code (0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 none)
//   rs_val   in   [31:0] forwarded rs operand
//   rt_val   in   [31:0] forwarded rt operand
//   start    out  combinational, high in the cycle a mult/div is accepted
//   busy     out  registered, high while a mult/div is in flight
//   hi       out  [31:0] HI register
//   lo       out  [31:0] LO register
//   mf_data  out  [31:0] combinational MFHI/MFLO read data, 0 otherwise

module mdu_ctrl #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10,
   parameter int unsigned CNT_W      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [3:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mf_data
);

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMfhi  = 4'd5;
   localparam logic [3:0] OpMflo  = 4'd6;
   localparam logic [3:0] OpMthi  = 4'd7;
   localparam logic [3:0] OpMtlo  = 4'd8;

   localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      res_hi_q, res_hi_d;
   logic [31:0]      res_lo_q, res_lo_d;
   logic             res_wr_q, res_wr_d;

   logic             accept;
   logic             is_div;
   logic             last_cycle;

   // ---------------------------------------------------------------------------
   // Arithmetic, evaluated on the E-stage operands every cycle
   // ---------------------------------------------------------------------------
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic               div_zero;
   logic [31:0]        divisor;
   logic [31:0]        quo_u, rem_u;
   logic [31:0]        rs_mag, rt_mag;
   logic [31:0]        quo_mag, rem_mag;
   logic [31:0]        quo_s, rem_s;

   assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   // Substitute a divisor of 1 on divide-by-zero so no X reaches the datapath;
   // the result is never committed in that case.
   assign div_zero = (rt_val == 32'd0);
   assign divisor  = div_zero ? 32'd1 : rt_val;

   assign quo_u = rs_val / divisor;
   assign rem_u = rs_val % divisor;

   // Signed divide on magnitudes: sidesteps the 0x80000000 / -1 overflow, whose
   // 32-bit wrapped quotient is 0x80000000 as required.
   assign rs_mag  = rs_val[31] ? (32'd0 - rs_val) : rs_val;
   assign rt_mag  = divisor[31] ? (32'd0 - divisor) : divisor;
   assign quo_mag = rs_mag / rt_mag;
   assign rem_mag = rs_mag % rt_mag;
   assign quo_s   = (rs_val[31] ^ divisor[31]) ? (32'd0 - quo_mag) : quo_mag;
   assign rem_s   = rs_val[31] ? (32'd0 - rem_mag) : rem_mag;

   // ---------------------------------------------------------------------------
   // Control decode
   // ---------------------------------------------------------------------------
   assign accept     = en && (state_q == StIdle) && !reset;
   assign is_div     = (op == OpDiv) || (op == OpDivu);
   assign last_cycle = (cnt_q == CntOne);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (last_cycle) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      busy    = (state_q == StRun);
      start   = 1'b0;
      mf_data = 32'd0;
      if (accept) begin
         case (op)
            OpMult, OpMultu, OpDiv, OpDivu: start = 1'b1;
            default:                        start = 1'b0;
         endcase
      end
      // MF* reads are not gated by busy: a stalled read just sees stale values.
      if (en) begin
         case (op)
            OpMfhi:  mf_data = hi_q;
            OpMflo:  mf_data = lo_q;
            default: mf_data = 32'd0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      res_wr_d = res_wr_q;

      if (start) begin
         cnt_d    = is_div ? DivLoad : MulLoad;
         res_wr_d = 1'b1;
         case (op)
            OpMult: begin
               res_hi_d = prod_s[63:32];
               res_lo_d = prod_s[31:0];
            end
            OpMultu: begin
               res_hi_d = prod_u[63:32];
               res_lo_d = prod_u[31:0];
            end
            OpDiv: begin
               res_hi_d = rem_s;
               res_lo_d = quo_s;
               res_wr_d = !div_zero;
            end
            default: begin
               res_hi_d = rem_u;
               res_lo_d = quo_u;
               res_wr_d = !div_zero;
            end
         endcase
      end else if (state_q == StRun) begin
         cnt_d = cnt_q - CntOne;
         if (last_cycle && res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
         end
      end else if (accept) begin
         case (op)
            OpMthi:  hi_d = rs_val;
            OpMtlo:  lo_d = rs_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         res_wr_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         res_wr_q <= res_wr_d;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl. Each mult/div issue pushes its
// expected busy length and final HI/LO into a scoreboard; a monitor pops and
// compares whenever busy falls.

module tb_mdu_ctrl;

   localparam logic [3:0] OpNone  = 4'd0;
   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMfhi  = 4'd5;
   localparam logic [3:0] OpMflo  = 4'd6;
   localparam logic [3:0] OpMthi  = 4'd7;
   localparam logic [3:0] OpMtlo  = 4'd8;

   logic        clk;
   logic        reset;
   logic        en;
   logic [3:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        start;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mf_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned cycles;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];

   mdu_ctrl #(
      .MUL_CYCLES(5),
      .DIV_CYCLES(10),
      .CNT_W     (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .start  (start),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo),
      .mf_data(mf_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue a mult/div in the current cycle; leaves the bus idle in the next.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned cyc, input logic [31:0] eh, input logic [31:0] el);
      exp_t e;
      en     = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      e.cycles = cyc;
      e.hi     = eh;
      e.lo     = el;
      sb.push_back(e);
      @(negedge clk);
      check("start_on_issue", {31'd0, start}, 32'd1);
      check("busy_on_issue", {31'd0, busy}, 32'd0);
      tick;
      en = 1'b0;
      op = OpNone;
   endtask

   // Returns in the first cycle with busy=0.
   task automatic wait_idle;
      int n = 0;
      while (busy !== 1'b0 && n < 64) begin
         tick;
         n++;
      end
      if (n >= 64) begin
         checks++;
         errors++;
         $display("FAIL wait_idle actual=busy_stuck required=idle_within_64");
      end
   endtask

   // Drive a non-mdu op for one cycle and check start stays low.
   task automatic drive_other(input logic [3:0] o, input logic [31:0] a, input logic e);
      en     = e;
      op     = o;
      rs_val = a;
      rt_val = 32'd0;
      @(negedge clk);
      check("start_low", {31'd0, start}, 32'd0);
   endtask

   // Monitor: on every busy falling edge, compare run length and HI/LO.
   initial begin
      int unsigned run_len = 0;
      logic        prev_busy = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            run_len++;
         end else if (prev_busy) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow actual=busy_fell required=expected_entry");
            end else begin
               e = sb.pop_front();
               check("busy_cycles", run_len, e.cycles);
               check("result_hi", hi, e.hi);
               check("result_lo", lo, e.lo);
            end
            run_len = 0;
         end
         prev_busy = (busy === 1'b1);
      end
   end

   initial begin
      reset  = 1'b1;
      en     = 1'b1;
      op     = OpMult;
      rs_val = 32'd3;
      rt_val = 32'd4;

      // Reset: start must stay low even with a valid MULT presented.
      tick;
      @(negedge clk);
      check("start_in_reset", {31'd0, start}, 32'd0);
      tick;
      reset = 1'b0;
      en    = 1'b0;
      op    = OpNone;
      @(negedge clk);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      tick;
      drive_other(OpMfhi, 32'd0, 1'b1);
      check("reset_mfhi", mf_data, 32'd0);
      tick;

      // MULT -2 * 3, then MF reads of the result.
      issue(OpMult, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      wait_idle();
      drive_other(OpMfhi, 32'd0, 1'b1);
      check("mfhi_mult", mf_data, 32'hFFFF_FFFF);
      tick;
      drive_other(OpMflo, 32'd0, 1'b1);
      check("mflo_mult", mf_data, 32'hFFFF_FFFA);
      tick;

      issue(OpMultu, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
      wait_idle();
      issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      wait_idle();
      issue(OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h8000_0000, 32'h0000_0000);
      wait_idle();
      issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
      wait_idle();

      // Divide by zero keeps the MT-written context.
      drive_other(OpMthi, 32'h0000_1234, 1'b1);
      tick;
      drive_other(OpMtlo, 32'h0000_5678, 1'b1);
      tick;
      en = 1'b0;
      check("mthi_value", hi, 32'h0000_1234);
      check("mtlo_value", lo, 32'h0000_5678);
      issue(OpDivu, 32'h0000_0099, 32'd0, 10, 32'h0000_1234, 32'h0000_5678);
      wait_idle();

      // Ops during busy are ignored; MF while busy sees stale values.
      issue(OpMult, 32'd3, 32'd5, 5, 32'd0, 32'd15);
      drive_other(OpMtlo, 32'h0000_CAFE, 1'b1);
      tick;
      drive_other(OpMflo, 32'd0, 1'b1);
      check("mflo_stale", mf_data, 32'h0000_5678);
      tick;
      drive_other(OpMult, 32'd9, 1'b1);
      tick;
      en = 1'b0;
      wait_idle();
      drive_other(OpMtlo, 32'h0000_CAFE, 1'b1);
      tick;
      en = 1'b0;
      check("mtlo_idle", lo, 32'h0000_CAFE);
      check("mtlo_keeps_hi", hi, 32'd0);

      // en=0: no reads, no writes.
      drive_other(OpMfhi, 32'd0, 1'b0);
      check("mf_disabled", mf_data, 32'd0);
      tick;
      drive_other(OpMthi, 32'hDEAD_BEEF, 1'b0);
      tick;
      check("mthi_disabled", hi, 32'd0);

      // Back-to-back: second issue in the first cycle busy is low.
      issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
      wait_idle();
      issue(OpDivu, 32'd15, 32'd4, 10, 32'd3, 32'd3);
      wait_idle();

      // Reset in the third busy cycle of a DIV discards the result.
      issue(OpDiv, 32'd100, 32'd7, 3, 32'd0, 32'd0);
      tick;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);

      issue(OpMult, 32'd6, 32'd7, 5, 32'd0, 32'd42);
      wait_idle();
      tick;
      tick;
      check("sb_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
